// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_AW = 8;
    localparam int unsigned DMEM_DW = 8;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        HLOCK  = 2'd1,
        HYIELD = 2'd2
    } arb_state_t;

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker: bit 0 = core, bit 1 = host.
// On a tie the requester that did not own the last grant wins.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic [1:0] gnt
);

    // One-hot grant selection
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_owner == OWN_HOST)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data memory between the core LS port and the
// host/loader port. Round-robin with an optional host burst lock that is
// forcibly broken after LOCK_MAX grants so the core cannot starve.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = DMEM_AW,
    parameter int unsigned DW       = DMEM_DW,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_core_stall,
    output logic [15:0]   stat_host_gnt
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt, lock_inc;
    owner_t        last_owner;
    owner_t        rd_owner;
    logic          rd_pend;
    logic [1:0]    rr_gnt;

    dmem_arb_rr u_rr (
        .req        ({host_req, core_req}),
        .last_owner (last_owner),
        .gnt        (rr_gnt)
    );

    // State register and burst-lock counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ARB;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Next-state: enter lock on a locked host grant, yield to core at LOCK_MAX
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        lock_inc     = (lock_cnt == CW'(LOCK_MAX)) ? lock_cnt : lock_cnt + CW'(1);
        case (state)
            ARB: begin
                if (host_gnt && host_lock) begin
                    state_nxt    = HLOCK;
                    lock_cnt_nxt = CW'(1);
                end
            end
            HLOCK: begin
                if (host_gnt) begin
                    lock_cnt_nxt = lock_inc;
                end
                if (!host_lock || !host_req) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else if (lock_cnt_nxt == CW'(LOCK_MAX) && core_req) begin
                    state_nxt    = HYIELD;
                    lock_cnt_nxt = '0;
                end
            end
            HYIELD: begin
                state_nxt = ARB;
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Grants and memory request mux; nothing is granted during Reset
    always_comb begin
        core_gnt  = 1'b0;
        host_gnt  = 1'b0;
        if (!Reset) begin
            case (state)
                ARB: begin
                    core_gnt = rr_gnt[0];
                    host_gnt = rr_gnt[1];
                end
                HLOCK:   host_gnt = host_req;
                HYIELD:  core_gnt = core_req;
                default: ;
            endcase
        end
        mem_en    = core_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Round-robin history and read-return tracking
    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_owner <= OWN_HOST;
            rd_pend    <= 1'b0;
            rd_owner   <= OWN_CORE;
        end else begin
            if (core_gnt) begin
                last_owner <= OWN_CORE;
            end else if (host_gnt) begin
                last_owner <= OWN_HOST;
            end
            rd_pend  <= (core_gnt && !core_we) || (host_gnt && !host_we);
            rd_owner <= core_gnt ? OWN_CORE : OWN_HOST;
        end
    end

    // Route returning read data to its owner; Reset drops an in-flight read
    assign core_rvalid = rd_pend && (rd_owner == OWN_CORE) && !Reset;
    assign host_rvalid = rd_pend && (rd_owner == OWN_HOST) && !Reset;
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] core_stall_q;
    logic [15:0] host_gnt_q;

    // Saturating core-stall and host-grant counters
    always_ff @(posedge CLK) begin
        if (Reset) begin
            core_stall_q <= '0;
            host_gnt_q   <= '0;
        end else begin
            if (core_req && !core_gnt) begin
                core_stall_q <= sat_inc16(core_stall_q);
            end
            if (host_gnt) begin
                host_gnt_q <= sat_inc16(host_gnt_q);
            end
        end
    end

    assign stat_core_stall = core_stall_q;
    assign stat_host_gnt   = host_gnt_q;
`else
    assign stat_core_stall = '0;
    assign stat_host_gnt   = '0;
`endif

endmodule
